stepper_sequencer: RTL and testbench
====================================

// Module: stepper_sequencer
// PURPOSE
//  Parametrised stepper-motor sequencer, successor to the fixed 4-state coil driver.
//  Executes commanded moves of N steps at a programmable step period.
//  Supports full-step (two-phase), half-step and wave-drive modes, and tracks absolute position.
//  Sits between the elevator controller (command side) and the coil driver pins (out).
// PARAMETERS
//  STEP_W     16       width of cmd_steps and of the remaining-step counter
//  DIV_W      20       width of cmd_period; clocks per step
//  RELEASE_CY 1000000  idle clocks before coil release (IDLE_RELEASE_EN only)
// PORTS
//  clk         in   1         system clock, rising edge
//  reset       in   1         asynchronous, active-low reset
//  cmd_valid   in   1         move request valid
//  cmd_ready   out  1         1 in IDLE; transfer on cmd_valid&cmd_ready
//  cmd_steps   in   STEP_W    number of steps to take
//  cmd_dir     in   1         1 = clockwise (index up), 0 = counter-clockwise
//  cmd_mode    in   2         00 full, 01 half, 10 wave, 11 reserved (treated as full)
//  cmd_period  in   DIV_W     clocks per step; 0 treated as 1
//  abort       in   1         stop current move at next edge
//  busy        out  1         1 in RUN
//  done        out  1         one-cycle pulse at move end (complete, zero-length or aborted)
//  aborted     out  1         valid with done; 1 if move ended by abort
//  position    out  STEP_W+1  signed absolute step count, wraps modulo 2^(STEP_W+1)
//  out         out  4         coil drive pattern
// BEHAVIOUR
//  - Reset: state IDLE, index 0, out=1010, position 0, busy 0, done 0, aborted 0, cmd_ready 1.
//  - Coil table, 3-bit index: 0:1010 1:0010 2:0110 3:0100 4:0101 5:0001 6:1001 7:1000.
//  - Full uses even indices, wave uses odd indices, both step +/-2; half steps +/-1; index wraps mod 8.
//  - Accept in IDLE: latch dir, mode, period, and remaining = cmd_steps; clear tick counter.
//    If index parity mismatches mode, index moves +1 (cw) or -1 (ccw) on the accept edge.
//    This realignment is not counted in position.
//  - cmd_steps==0: stay IDLE; done=1, aborted=0 on the cycle after accept; no motion.
//  - RUN: tick counter counts 0..period-1. At terminal count: index steps, position +/-1, remaining -1.
//    First step is registered period cycles after the accept edge; period=1 gives one step per clock.
//  - Final step (remaining 1->0): return to IDLE on that edge. done=1 and busy=0 in the following cycle.
//  - abort in RUN: IDLE at next edge with no step on that edge, even if a tick coincides.
//    done=1 and aborted=1 in the following cycle. abort in IDLE is ignored.
//  - cmd_valid while busy is not accepted (cmd_ready=0). Inputs are held by the master.
//  - Async reset mid-move: immediate return to reset values; position is lost.
// CONFIGURATION
//  IDLE_RELEASE_EN defined:
//   - After RELEASE_CY consecutive IDLE clocks, out=0000 (coils de-energised); index is retained.
//   - Acceptance clears the idle counter and restores out=table[index] on the accept edge.
//  IDLE_RELEASE_EN undefined:
//   - out=table[index] at all times, so holding torque is always applied.
// STRUCTURE
//  - Package stepper_pkg: mode encodings (MODE_FULL/HALF/WAVE), 8-entry COIL_TABLE constant, state encodings IDLE/RUN.
//  - Sub-module step_rate_gen: DIV_W tick divider with clear, period latch and 0->1 clamp.
//    Outputs a one-cycle tick.
//  - Top level holds the FSM, index, step counters, position and the release counter.
// TESTING
//  1. Reset low mid-move, then release -> out=1010, position=0, cmd_ready=1, busy=0.
//  2. full, cw, steps=4, period=3 -> out 0110,0101,1001,1010.
//     Steps at +3,+6,+9,+12 clocks; position=4; done pulse once.
//  3. half, ccw, steps=3, period=1 from index 0 -> out 1000,1001,0001; position=-3.
//  4. wave from index 0, cw, steps=2 -> realign to 0010 on the accept edge, then 0100,0001; position=2.
//  5. steps=10, period=5, abort after the 2nd step -> no 3rd step; position=2; done=aborted=1 for one cycle.
//  6. steps=0 -> done the next cycle, out unchanged.
//     With IDLE_RELEASE_EN and RELEASE_CY=8 -> out=0000 after 8 idle clocks; pattern restored on the next accept.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared encodings for the stepper sequencer: FSM states, drive modes and the coil table.
package stepper_pkg;

  typedef enum logic {IDLE, RUN} state_e;

  typedef enum logic [1:0] {
    MODE_FULL = 2'b00,
    MODE_HALF = 2'b01,
    MODE_WAVE = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  // Element i is the coil pattern for index i.
  localparam logic [7:0][3:0] COIL_TABLE = {
    4'b1000, 4'b1001, 4'b0001, 4'b0101, 4'b0100, 4'b0110, 4'b0010, 4'b1010
  };

  // The reserved encoding drives exactly like full-step.
  function automatic mode_e mode_norm(input logic [1:0] raw);
    return (raw == MODE_RSVD) ? MODE_FULL : mode_e'(raw);
  endfunction

  function automatic logic [2:0] step_delta(input mode_e mode);
    return (mode == MODE_HALF) ? 3'd1 : 3'd2;
  endfunction

  // Full-step lives on even indices, wave drive on odd ones.
  function automatic logic misaligned(input mode_e mode, input logic [2:0] idx);
    logic mis;
    mis = 1'b0;
    if (mode == MODE_FULL) mis = idx[0];
    if (mode == MODE_WAVE) mis = ~idx[0];
    return mis;
  endfunction

endpackage

// File: rtl/step_rate_gen.sv
// Step-rate divider: counts 0..period-1 and emits a one-cycle tick at terminal count.
module step_rate_gen #(
  parameter int unsigned DIV_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             enable,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] period_clamped;

  assign period_clamped = (period == '0) ? DIV_W'(1) : period;
  assign tick           = enable && (cnt_q == period_q - DIV_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_q <= DIV_W'(1);
      cnt_q    <= '0;
    end else begin
      if (load) period_q <= period_clamped;
      if (clear) begin
        cnt_q <= '0;
      end else if (enable) begin
        cnt_q <= tick ? '0 : cnt_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/stepper_sequencer.sv
// Stepper-motor move sequencer with full/half/wave drive and absolute position tracking.
// Optional coil release after a long idle period is enabled by defining IDLE_RELEASE_EN.
module stepper_sequencer import stepper_pkg::*; #(
  parameter int unsigned STEP_W     = 16,
  parameter int unsigned DIV_W      = 20,
  parameter int unsigned RELEASE_CY = 1000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [STEP_W-1:0]        cmd_steps,
  input  logic                     cmd_dir,
  input  logic [1:0]               cmd_mode,
  input  logic [DIV_W-1:0]         cmd_period,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic signed [STEP_W:0]   position,
  output logic [3:0]               out
);

  state_e                 state_q, state_d;
  mode_e                  mode_q, mode_d, cmd_mode_n;
  logic                   dir_q, dir_d;
  logic [2:0]             index_q, index_d;
  logic [STEP_W-1:0]      remaining_q, remaining_d;
  logic signed [STEP_W:0] position_q, position_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;
  logic                   accept, tick, step_en, last_step, released;

  assign cmd_mode_n = mode_norm(cmd_mode);
  assign accept     = cmd_valid && (state_q == IDLE);
  assign last_step  = (remaining_q == STEP_W'(1));
  // Abort wins over a coinciding tick.
  assign step_en    = (state_q == RUN) && tick && !abort;

  step_rate_gen #(
    .DIV_W (DIV_W)
  ) u_rate (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .load   (accept),
    .enable (state_q == RUN),
    .period (cmd_period),
    .tick   (tick)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && (cmd_steps != '0)) state_d = RUN;
      RUN: begin
        if (abort)                      state_d = IDLE;
        else if (tick && last_step)     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state
  always_comb begin
    mode_d      = mode_q;
    dir_d       = dir_q;
    index_d     = index_q;
    remaining_d = remaining_q;
    position_d  = position_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    if (accept) begin
      mode_d      = cmd_mode_n;
      dir_d       = cmd_dir;
      remaining_d = cmd_steps;
      done_d      = (cmd_steps == '0);
      // Realignment onto the mode's index parity is not counted as a step.
      if (misaligned(cmd_mode_n, index_q)) begin
        index_d = cmd_dir ? index_q + 3'd1 : index_q - 3'd1;
      end
    end else if (state_q == RUN) begin
      if (abort) begin
        done_d    = 1'b1;
        aborted_d = 1'b1;
      end else if (step_en) begin
        index_d     = dir_q ? index_q + step_delta(mode_q) : index_q - step_delta(mode_q);
        position_d  = dir_q ? position_q + (STEP_W+1)'(1) : position_q - (STEP_W+1)'(1);
        remaining_d = remaining_q - STEP_W'(1);
        done_d      = last_step;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q      <= MODE_FULL;
      dir_q       <= 1'b0;
      index_q     <= 3'd0;
      remaining_q <= '0;
      position_q  <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      dir_q       <= dir_d;
      index_q     <= index_d;
      remaining_q <= remaining_d;
      position_q  <= position_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

`ifdef IDLE_RELEASE_EN
  localparam int unsigned RelW = $clog2(RELEASE_CY + 1);

  logic [RelW-1:0] idle_cnt_q;

  assign released = (idle_cnt_q == RelW'(RELEASE_CY));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt_q <= '0;
    end else if ((state_q != IDLE) || accept) begin
      idle_cnt_q <= '0;
    end else if (!released) begin
      idle_cnt_q <= idle_cnt_q + RelW'(1);
    end
  end
`else
  logic unused_release_cy;
  assign unused_release_cy = ^32'(RELEASE_CY);
  assign released          = 1'b0;
`endif

  // Outputs
  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q == RUN);
    done      = done_q;
    aborted   = aborted_q;
    position  = position_q;
    out       = released ? 4'b0000 : COIL_TABLE[index_q];
  end

endmodule

// File: tb/tb_stepper_sequencer.sv
// Directed scoreboard bench for stepper_sequencer; release test runs when IDLE_RELEASE_EN is defined.
module tb_stepper_sequencer;

  localparam int unsigned RCY = 1000;

  typedef struct {
    logic [3:0]         o;
    logic signed [16:0] p;
    int                 off;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [15:0]        cmd_steps;
  logic               cmd_dir;
  logic [1:0]         cmd_mode;
  logic [19:0]        cmd_period;
  logic               abort;
  logic               busy;
  logic               done;
  logic               aborted;
  logic signed [16:0] position;
  logic [3:0]         out;

  int                 n_cmp = 0;
  int                 n_fail = 0;
  int                 cyc = 0;
  int                 acc;
  exp_t               exp_q[$];
  logic [3:0]         tbl [8];
  int                 midx;
  logic signed [16:0] mpos;
  logic [3:0]         last_out;

  stepper_sequencer #(
    .STEP_W     (16),
    .DIV_W      (20),
    .RELEASE_CY (RCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_dir    (cmd_dir),
    .cmd_mode   (cmd_mode),
    .cmd_period (cmd_period),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .position   (position),
    .out        (out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Push the expected coil/position sequence for a move of n_do steps.
  task automatic plan(input bit dir, input logic [1:0] mode, input int period, input int n_do);
    int p;
    int stp;
    bit mis;
    p   = (period == 0) ? 1 : period;
    stp = (mode == 2'b01) ? 1 : 2;
    mis = ((mode == 2'b10) && (midx % 2 == 0)) ||
          ((mode != 2'b01) && (mode != 2'b10) && (midx % 2 == 1));
    if (mis) begin
      midx = (midx + (dir ? 1 : 7)) % 8;
      exp_q.push_back('{tbl[midx], mpos, 0});
    end
    for (int j = 1; j <= n_do; j++) begin
      midx = (midx + (dir ? stp : 8 - stp)) % 8;
      mpos = dir ? mpos + 17'sd1 : mpos - 17'sd1;
      exp_q.push_back('{tbl[midx], mpos, p * j});
    end
  endtask

  task automatic run(input int steps, input bit dir, input logic [1:0] mode, input int period,
                     input int n_do, input int abort_at, input int done_off, input bit exp_ab);
    exp_t e;
    int   off;
    bit   seen;
    plan(dir, mode, period, n_do);
    cmd_steps  = 16'(steps);
    cmd_dir    = dir;
    cmd_mode   = mode;
    cmd_period = 20'(period);
    cmd_valid  = 1'b1;
    chk("ready_before_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc       = cyc;
    seen      = 1'b0;
    for (int n = 0; n < done_off + 6 && !seen; n++) begin
      @(negedge clk);
      off = cyc - acc;
      if (out !== last_out) begin
        chk("out_change_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("step_out", 32'(out), 32'(e.o));
          chk("step_pos", 32'(position), 32'(e.p));
          chk("step_time", 32'(off), 32'(e.off));
        end
        last_out = out;
      end
      if (done) begin
        seen = 1'b1;
        chk("done_time", 32'(off), 32'(done_off));
        chk("done_aborted", 32'(aborted), 32'(exp_ab));
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_ready", 32'(cmd_ready), 32'd1);
        chk("done_pos", 32'(position), 32'(mpos));
      end else begin
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_ready", 32'(cmd_ready), 32'd0);
      end
      if (abort_at > 0 && off == abort_at) abort = 1'b1;
    end
    abort = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("steps_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    tbl        = '{4'b1010, 4'b0010, 4'b0110, 4'b0100, 4'b0101, 4'b0001, 4'b1001, 4'b1000};
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_steps  = '0;
    cmd_dir    = 1'b0;
    cmd_mode   = 2'b00;
    cmd_period = '0;
    abort      = 1'b0;
    midx       = 0;
    mpos       = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_out", 32'(out), 32'b1010);
    chk("rst_pos", 32'(position), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);

    // Reset asserted in the middle of a move.
    cmd_steps = 16'd5; cmd_dir = 1'b1; cmd_mode = 2'b00; cmd_period = 20'd2; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_moved", 32'(out), 32'b0110);
    reset = 1'b0;
    #1;
    chk("async_out", 32'(out), 32'b1010);
    chk("async_pos", 32'(position), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(cmd_ready), 32'd1);
    chk("rel_out", 32'(out), 32'b1010);
    last_out = out;

    run(4, 1'b1, 2'b00, 3, 4, 0, 12, 1'b0);       // full cw
    run(3, 1'b0, 2'b01, 1, 3, 0, 3, 1'b0);        // half ccw, one step per clock

    abort = 1'b1;                                  // ignored while idle
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_done", 32'(done), 32'd0);
    chk("idle_abort_out", 32'(out), 32'(tbl[midx]));
    @(negedge clk);

    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    midx = 0; mpos = '0;
    @(negedge clk);
    last_out = out;

    run(2, 1'b1, 2'b10, 2, 2, 0, 4, 1'b0);        // wave cw with realign
    run(10, 1'b1, 2'b00, 5, 2, 14, 15, 1'b1);     // abort coinciding with a tick
    run(2, 1'b0, 2'b11, 0, 2, 0, 2, 1'b0);        // reserved mode, period 0
    run(0, 1'b1, 2'b00, 4, 0, 0, 0, 1'b0);        // zero-length move
    chk("zero_out", 32'(out), 32'(tbl[midx]));

`ifdef IDLE_RELEASE_EN
    repeat (RCY + 2) @(negedge clk);
    chk("released_out", 32'(out), 32'b0000);
    last_out = out;
    exp_q.push_back('{tbl[midx], mpos, 0});
    run(0, 1'b1, 2'b00, 1, 0, 0, 0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
